// File: rtl/enc_bundler_pkg.sv
// Shared encoder constants, lane array type and bundler FSM states.
// Imported by the binder packs and the bundler.
package enc_bundler_pkg;

  localparam int HV_DIM     = 16;
  localparam int NUM_LANES  = 10;
  localparam int N_FEATURES = 30;
  localparam int NUM_BEATS  = N_FEATURES / NUM_LANES;
  localparam int THRESHOLD  = 2;

  typedef logic [HV_DIM-1:0] hv_lane_t [0:NUM_LANES-1];

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    THRESH
  } bund_state_t;

endpackage

// File: rtl/enc_bundle_counter.sv
// One dimension's lane popcount and set-bit accumulator; count updates one cycle after accumulate.
// No backpressure: every enabled cycle is added.
module enc_bundle_counter #(
  parameter int NUM_LANES = 10,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clear,
  input  logic                 acc_en,
  input  logic [NUM_LANES-1:0] lane_bits,
  output logic [CNT_W-1:0]     count
);

  logic [CNT_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + CNT_W'(lane_bits[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (acc_en) begin
      count <= count + pop;
    end
  end

endmodule

// File: rtl/enc_bundler.sv
// Accumulates NUM_BEATS beats of bound lanes per sample and thresholds them into one sample hypervector.
// Result registered one cycle after the last beat; beats wait for in_valid, no backpressure to the binder.
import enc_bundler_pkg::*;

module enc_bundler #(
  parameter int HV_DIM    = enc_bundler_pkg::HV_DIM,
  parameter int NUM_LANES = enc_bundler_pkg::NUM_LANES,
  parameter int NUM_BEATS = enc_bundler_pkg::NUM_BEATS,
  parameter int THRESHOLD = enc_bundler_pkg::THRESHOLD,
  parameter int CNT_W     = $clog2(NUM_LANES * NUM_BEATS + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_bundling,
  input  logic              in_valid,
  input  logic [HV_DIM-1:0] shifted_hv [0:NUM_LANES-1],
  output logic              busy,
  output logic [HV_DIM-1:0] sample_hv,
  output logic              out_valid
);

  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  bund_state_t       state, next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              clear, acc_en, last_beat;
  logic [CNT_W-1:0]  counts [HV_DIM];
  logic [HV_DIM-1:0] thresh_hv;

  assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [NUM_LANES-1:0] bits;

    always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
        bits[i] = shifted_hv[i][d];
      end
    end

    enc_bundle_counter #(
      .NUM_LANES(NUM_LANES),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .nrst     (nrst),
      .clear    (clear),
      .acc_en   (acc_en),
      .lane_bits(bits),
      .count    (counts[d])
    );

    assign thresh_hv[d] = (counts[d] >= CNT_W'(THRESHOLD));
  end

  // A start seen in THRESH chains straight into the next sample; the compare
  // still reads the old counts because the clear lands on the same edge.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    acc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start_bundling) begin
          clear      = 1'b1;
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_en = 1'b1;
          if (last_beat) next_state = THRESH;
        end
      end
      THRESH: begin
        if (start_bundling) begin
          clear      = 1'b1;
          next_state = ACCUM;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      sample_hv <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (state == THRESH);
      if (state == THRESH) begin
        sample_hv <= thresh_hv;
        busy      <= 1'b0;
      end
      if (clear) begin
        beat_cnt <= '0;
        busy     <= 1'b1;
      end else if (acc_en) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enc_bundler.sv
// Directed bench for enc_bundler at HV_DIM=16, NUM_BEATS=3, THRESHOLD=2.
import enc_bundler_pkg::*;

module tb_enc_bundler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_bundling;
  logic        in_valid;
  hv_lane_t    shv;
  logic        busy;
  logic [15:0] sample_hv;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt = 0;

  enc_bundler #(
    .HV_DIM   (16),
    .NUM_LANES(10),
    .NUM_BEATS(3),
    .THRESHOLD(2)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start_bundling(start_bundling),
    .in_valid      (in_valid),
    .shifted_hv    (shv),
    .busy          (busy),
    .sample_hv     (sample_hv),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hv();
    for (int i = 0; i < 10; i++) shv[i] = 16'h0000;
  endtask

  task automatic all_lanes(input logic [15:0] v);
    for (int i = 0; i < 10; i++) shv[i] = v;
  endtask

  task automatic start();
    start_bundling = 1'b1;
    tick();
    start_bundling = 1'b0;
  endtask

  task automatic beat();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the last beat edge E.
  task automatic finish_sample(input string tag, input logic [15:0] exp_hv);
    int ov0;
    ov0 = ov_cnt;
    check({tag, "_ov_early"}, out_valid, 1'b0);
    check({tag, "_busy_thresh"}, busy, 1'b1);
    tick();
    check({tag, "_ov"}, out_valid, 1'b1);
    check({tag, "_hv"}, sample_hv, exp_hv);
    check({tag, "_busy_done"}, busy, 1'b0);
    tick();
    check({tag, "_ov_fall"}, out_valid, 1'b0);
    check({tag, "_hv_hold"}, sample_hv, exp_hv);
    check({tag, "_ov_pulses"}, ov_cnt - ov0, 1);
  endtask

  initial begin
    int ov0;
    nrst = 1'b1;
    start_bundling = 1'b0;
    in_valid = 1'b0;
    clr_hv();
    tick();
    tick();
    nrst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_ov", out_valid, 1'b0);
    check("rst_hv", sample_hv, 16'h0000);

    // Single bit per beat
    start();
    check("s1_busy_start", busy, 1'b1);
    clr_hv();
    shv[0] = 16'h0020;
    beat(); beat(); beat();
    finish_sample("s1", 16'h0020);

    // Threshold boundary: bit3 x1, bit4 x2, bit7 x30
    start();
    all_lanes(16'h0080);
    shv[0] = 16'h0088;
    shv[1] = 16'h0090;
    beat();
    all_lanes(16'h0080);
    shv[2] = 16'h0090;
    beat();
    all_lanes(16'h0080);
    beat();
    finish_sample("s2", 16'h0090);

    // Gapped beats with stray in_valid in IDLE and alongside start
    ov0 = ov_cnt;
    clr_hv();
    shv[0] = 16'h0100;
    beat();
    tick();
    beat();
    check("s3_idle_busy", busy, 1'b0);
    all_lanes(16'hFFFF);
    in_valid = 1'b1;
    start();
    in_valid = 1'b0;
    check("s3_busy_start", busy, 1'b1);
    clr_hv();
    shv[0] = 16'h0020;
    beat();
    repeat (4) tick();
    beat();
    repeat (4) tick();
    check("s3_busy_gap", busy, 1'b1);
    check("s3_no_early_ov", ov_cnt - ov0, 0);
    beat();
    finish_sample("s3", 16'h0020);

    // Start while busy is ignored
    start();
    clr_hv();
    shv[0] = 16'h0001;
    shv[1] = 16'h0002;
    beat();
    clr_hv();
    start();
    check("s4_busy_restart", busy, 1'b1);
    shv[0] = 16'h0001;
    beat();
    clr_hv();
    shv[0] = 16'h0004;
    shv[1] = 16'h0004;
    beat();
    finish_sample("s4", 16'h0005);

    // Reset mid-ACCUM
    ov0 = ov_cnt;
    start();
    all_lanes(16'hFFFF);
    beat(); beat();
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    clr_hv();
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_hv", sample_hv, 16'h0000);
    tick();
    tick();
    check("s5_rst_no_ov", ov_cnt - ov0, 0);
    start();
    beat(); beat(); beat();
    finish_sample("s5", 16'h0000);

    // Back-to-back: start in THRESH cycle
    start();
    all_lanes(16'hFFFF);
    beat(); beat(); beat();
    clr_hv();
    start_bundling = 1'b1;
    tick();
    start_bundling = 1'b0;
    check("s6a_ov", out_valid, 1'b1);
    check("s6a_hv", sample_hv, 16'hFFFF);
    check("s6b_busy_chain", busy, 1'b1);
    beat(); beat(); beat();
    finish_sample("s6b", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
